// File: rtl/imem_loader_ctrl_if.sv
// Host word stream, instruction-memory write port and data-memory store snoop
// shared by imem_loader_ctrl and whatever drives or observes it.
interface imem_loader_ctrl_if #(
  parameter int unsigned AW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          dmem_write;
  logic [31:0]   dmem_addr;
  logic [31:0]   dmem_wdata;

  // master: host / harness side that supplies words and observes the writes
  modport master (
    output in_valid, in_data, dmem_write, dmem_addr, dmem_wdata,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  // slave: the loader controller
  modport slave (
    input  in_valid, in_data, dmem_write, dmem_addr, dmem_wdata,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_ctrl.sv
// Test-harness sequencer: loads a program into instruction memory with the core
// held in reset, pads with NOPs, runs the core and watches for the tohost store.
module imem_loader_ctrl #(
  parameter int unsigned IMEM_DEPTH  = 64,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FFC,
  parameter int unsigned TIMEOUT     = 10000,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  localparam int unsigned AW         = $clog2(IMEM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [AW:0]         load_len,
  input  logic                abort,
  imem_loader_ctrl_if.slave   bus,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                timed_out,
  output logic [31:0]         result,
  output logic [31:0]         cycle_count
);

  localparam logic [AW:0]  DEPTH_W   = IMEM_DEPTH[AW:0];
  localparam logic [AW:0]  LAST_W    = DEPTH_W - 1'b1;
  localparam logic [31:0]  TIMEOUT_W = TIMEOUT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  logic [AW:0] len;
  logic [AW:0] ptr;
  logic [AW:0] ptr_inc;
  logic [AW:0] len_clamped;
  logic        rel_second;
  logic        tohost_hit;

  always_comb begin
    ptr_inc     = ptr + 1'b1;
    len_clamped = (load_len > DEPTH_W) ? DEPTH_W : load_len;
    tohost_hit  = bus.dmem_write && (bus.dmem_addr == TOHOST_ADDR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      len            <= '0;
      ptr            <= '0;
      rel_second     <= 1'b0;
      cpu_rst        <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      timed_out      <= 1'b0;
      result         <= '0;
      cycle_count    <= '0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (abort) begin
        // result and cycle_count are left intact so a host can inspect an aborted run
        state        <= S_IDLE;
        cpu_rst      <= 1'b1;
        busy         <= 1'b0;
        done         <= 1'b0;
        timed_out    <= 1'b0;
        bus.in_ready <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start && (load_len != '0)) begin
              state        <= S_LOAD;
              len          <= len_clamped;
              ptr          <= '0;
              busy         <= 1'b1;
              done         <= 1'b0;
              timed_out    <= 1'b0;
              result       <= '0;
              cycle_count  <= '0;
              bus.in_ready <= 1'b1;
            end
          end

          S_LOAD: begin
            if (bus.in_valid && bus.in_ready) begin
              bus.imem_we    <= 1'b1;
              bus.imem_waddr <= ptr[AW-1:0];
              bus.imem_wdata <= bus.in_data;
              ptr            <= ptr_inc;
              if (ptr_inc == len) begin
                bus.in_ready <= 1'b0;
                rel_second   <= 1'b0;
                state        <= (len == DEPTH_W) ? S_RELEASE : S_FILL;
              end
            end
          end

          S_FILL: begin
            bus.imem_we    <= 1'b1;
            bus.imem_waddr <= ptr[AW-1:0];
            bus.imem_wdata <= NOP_WORD;
            ptr            <= ptr_inc;
            if (ptr == LAST_W) begin
              rel_second <= 1'b0;
              state      <= S_RELEASE;
            end
          end

          S_RELEASE: begin
            // Two cycles of reset after the final write; the count is preloaded so
            // the first RUN cycle already reads 1.
            if (rel_second) begin
              state       <= S_RUN;
              cpu_rst     <= 1'b0;
              cycle_count <= 32'd1;
            end else begin
              rel_second <= 1'b1;
            end
          end

          S_RUN: begin
            if (tohost_hit) begin
              result  <= bus.dmem_wdata;
              done    <= 1'b1;
              busy    <= 1'b0;
              cpu_rst <= 1'b1;
              state   <= S_DONE;
            end else if (cycle_count >= TIMEOUT_W) begin
              done      <= 1'b1;
              timed_out <= 1'b1;
              busy      <= 1'b0;
              cpu_rst   <= 1'b1;
              state     <= S_DONE;
            end else if (cycle_count != '1) begin
              cycle_count <= cycle_count + 32'd1;
            end
          end

          default: begin
            state        <= S_IDLE;
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
            bus.in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
